// File: rtl/neuron_layer_scheduler_if.sv
// rtl/neuron_layer_scheduler_if.sv - Bus bundle between the MLP scheduler, its ROM buses and the classifier.
// ARGMAX_EN adds the class_idx result.
interface neuron_layer_scheduler_if #(
    parameter int INPUT_COUNT   = 62,
    parameter int H_NODE_NUMBER = 20,
    parameter int O_NODE_NUMBER = 10
);
`ifdef ARGMAX_EN
    localparam int CLS_W = (O_NODE_NUMBER > 1) ? $clog2(O_NODE_NUMBER) : 1;
`endif

    logic                                     start_signal;
    logic [INPUT_COUNT*8-1:0]                 inputs;
    logic [INPUT_COUNT*H_NODE_NUMBER*8-1:0]   H_weights;
    logic [H_NODE_NUMBER*O_NODE_NUMBER*8-1:0] O_weights;
    logic [H_NODE_NUMBER*8-1:0]               H_bias;
    logic [O_NODE_NUMBER*8-1:0]               O_bias;
    logic [O_NODE_NUMBER*8-1:0]               out_regs;
    logic [H_NODE_NUMBER*8-1:0]               hidden_regs;
    logic                                     busy;
    logic                                     ready_signal;
`ifdef ARGMAX_EN
    logic [CLS_W-1:0]                         class_idx;
`endif

    modport master (
        output start_signal, inputs, H_weights, O_weights, H_bias, O_bias,
        input  out_regs, hidden_regs, busy, ready_signal
`ifdef ARGMAX_EN
        , class_idx
`endif
    );

    modport slave (
        input  start_signal, inputs, H_weights, O_weights, H_bias, O_bias,
        output out_regs, hidden_regs, busy, ready_signal
`ifdef ARGMAX_EN
        , class_idx
`endif
    );
endinterface

// File: rtl/neuron_layer_scheduler.sv
// rtl/neuron_layer_scheduler.sv - Two-layer MLP inference, LANES MAC lanes time-multiplexed over node groups.
// ARGMAX_EN adds a registered argmax of the output layer (class_idx).
module neuron_layer_scheduler #(
    parameter int INPUT_COUNT   = 62,
    parameter int H_NODE_NUMBER = 20,
    parameter int O_NODE_NUMBER = 10,
    parameter int LANES         = 10,
    parameter int FRAC          = 5,
    parameter int ACC_W         = 24
) (
    input  logic clk,
    input  logic rst,
    neuron_layer_scheduler_if.slave bus
);
    localparam int GH      = (H_NODE_NUMBER + LANES - 1) / LANES;
    localparam int GO      = (O_NODE_NUMBER + LANES - 1) / LANES;
    localparam int MAX_FAN = (INPUT_COUNT > H_NODE_NUMBER) ? INPUT_COUNT : H_NODE_NUMBER;
    localparam int MAX_G   = (GH > GO) ? GH : GO;
    localparam int MAX_N   = (H_NODE_NUMBER > O_NODE_NUMBER) ? H_NODE_NUMBER : O_NODE_NUMBER;
    localparam int KW      = $clog2(MAX_FAN + 1);
    localparam int GW      = $clog2(MAX_G + 1);
    localparam int BW      = $clog2(MAX_N + LANES + 1);
`ifdef ARGMAX_EN
    localparam int CLS_W   = (O_NODE_NUMBER > 1) ? $clog2(O_NODE_NUMBER) : 1;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                     state_q;
    logic                       layer_q;
    logic [GW-1:0]              group_q;
    logic [KW-1:0]              k_q;
    logic [BW-1:0]              base_q;
    logic signed [ACC_W-1:0]    acc_q [LANES];
    logic [H_NODE_NUMBER*8-1:0] hidden_q;
    logic [O_NODE_NUMBER*8-1:0] out_q;
    logic                       busy_q;
    logic                       ready_q;

    logic signed [ACC_W-1:0]    acc_d [LANES];
    logic [7:0]                 act_d [LANES];
    logic [BW-1:0]              lane_node_d [LANES];
    logic [LANES-1:0]           lane_en_d;
    logic                       last_k;
    logic                       last_g;
`ifdef ARGMAX_EN
    logic [7:0]                 best_q, best_d;
    logic [CLS_W-1:0]           class_q, class_d;
`endif

    always_comb begin
        int                      node;
        logic signed [7:0]       xk, wk, bk;
        logic signed [15:0]      prod;
        logic signed [ACC_W-1:0] sum, shr;
        node   = 0;
        xk     = '0;
        wk     = '0;
        bk     = '0;
        prod   = '0;
        sum    = '0;
        shr    = '0;
        last_k = layer_q ? (k_q == KW'(H_NODE_NUMBER - 1)) : (k_q == KW'(INPUT_COUNT - 1));
        last_g = layer_q ? (group_q == GW'(GO - 1)) : (group_q == GW'(GH - 1));
        for (int l = 0; l < LANES; l++) begin
            node           = int'(base_q) + l;
            lane_node_d[l] = BW'(node);
            xk             = '0;
            wk             = '0;
            bk             = '0;
            // Lanes past the end of a partial group see zero weight and bias.
            if (layer_q) begin
                lane_en_d[l] = (node < O_NODE_NUMBER);
                xk = hidden_q[int'(k_q)*8 +: 8];
                if (lane_en_d[l]) begin
                    wk = bus.O_weights[(node*H_NODE_NUMBER + int'(k_q))*8 +: 8];
                    bk = bus.O_bias[node*8 +: 8];
                end
            end else begin
                lane_en_d[l] = (node < H_NODE_NUMBER);
                xk = bus.inputs[int'(k_q)*8 +: 8];
                if (lane_en_d[l]) begin
                    wk = bus.H_weights[(node*INPUT_COUNT + int'(k_q))*8 +: 8];
                    bk = bus.H_bias[node*8 +: 8];
                end
            end
            prod     = xk * wk;
            acc_d[l] = acc_q[l] + ACC_W'(prod);
            sum      = acc_q[l] + (ACC_W'(bk) <<< FRAC);
            shr      = sum >>> FRAC;
            if (shr[ACC_W-1])
                act_d[l] = 8'd0;
            else if (shr > ACC_W'(127))
                act_d[l] = 8'd127;
            else
                act_d[l] = shr[7:0];
        end
`ifdef ARGMAX_EN
        // Running max over groups; lanes are scanned in node order so strict > keeps the lowest index on ties.
        best_d  = (group_q == '0) ? 8'd0 : best_q;
        class_d = (group_q == '0) ? '0 : class_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_en_d[l] && (act_d[l] > best_d)) begin
                best_d  = act_d[l];
                class_d = CLS_W'(lane_node_d[l]);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            layer_q  <= 1'b0;
            group_q  <= '0;
            k_q      <= '0;
            base_q   <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
            hidden_q <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef ARGMAX_EN
            best_q   <= '0;
            class_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_signal) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        layer_q <= 1'b0;
                        group_q <= '0;
                    end
                end
                S_LOAD: begin
                    for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
                    base_q  <= BW'(int'(group_q) * LANES);
                    k_q     <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
                    k_q <= k_q + 1'b1;
                    if (last_k) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_en_d[l]) begin
                            if (layer_q) out_q[int'(lane_node_d[l])*8 +: 8] <= act_d[l];
                            else         hidden_q[int'(lane_node_d[l])*8 +: 8] <= act_d[l];
                        end
                    end
`ifdef ARGMAX_EN
                    if (layer_q) begin
                        best_q  <= best_d;
                        class_q <= class_d;
                    end
`endif
                    if (!last_g) begin
                        group_q <= group_q + 1'b1;
                        state_q <= S_LOAD;
                    end else if (!layer_q) begin
                        layer_q <= 1'b1;
                        group_q <= '0;
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_regs     = out_q;
    assign bus.hidden_regs  = hidden_q;
    assign bus.busy         = busy_q;
    assign bus.ready_signal = ready_q;
`ifdef ARGMAX_EN
    assign bus.class_idx    = class_q;
`endif
endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// tb/tb_neuron_layer_scheduler.sv - Self-checking bench for neuron_layer_scheduler (LANES=10 and LANES=8 instances).
module tb_neuron_layer_scheduler;
    localparam int IC    = 62;
    localparam int HN    = 20;
    localparam int ON    = 10;
    localparam int FRAC  = 5;
    localparam int ACC_W = 24;
    localparam int CW    = (ON > 1) ? $clog2(ON) : 1;

    logic clk = 1'b0;
    logic rst;
    logic start0, start8;
    always #5 clk = ~clk;

    logic signed [7:0] x_a  [IC];
    logic signed [7:0] hw_a [HN*IC];
    logic signed [7:0] ow_a [ON*HN];
    logic signed [7:0] hb_a [HN];
    logic signed [7:0] ob_a [ON];

    logic [IC*8-1:0]    in_v;
    logic [IC*HN*8-1:0] hw_v;
    logic [HN*ON*8-1:0] ow_v;
    logic [HN*8-1:0]    hb_v;
    logic [ON*8-1:0]    ob_v;

    always_comb begin
        in_v = '0; hw_v = '0; ow_v = '0; hb_v = '0; ob_v = '0;
        for (int i = 0; i < IC; i++)    in_v[i*8 +: 8] = x_a[i];
        for (int i = 0; i < HN*IC; i++) hw_v[i*8 +: 8] = hw_a[i];
        for (int i = 0; i < ON*HN; i++) ow_v[i*8 +: 8] = ow_a[i];
        for (int i = 0; i < HN; i++)    hb_v[i*8 +: 8] = hb_a[i];
        for (int i = 0; i < ON; i++)    ob_v[i*8 +: 8] = ob_a[i];
    end

    neuron_layer_scheduler_if #(.INPUT_COUNT(IC), .H_NODE_NUMBER(HN), .O_NODE_NUMBER(ON)) if0 ();
    neuron_layer_scheduler_if #(.INPUT_COUNT(IC), .H_NODE_NUMBER(HN), .O_NODE_NUMBER(ON)) if8 ();

    assign if0.start_signal = start0;
    assign if0.inputs = in_v;  assign if0.H_weights = hw_v; assign if0.O_weights = ow_v;
    assign if0.H_bias = hb_v;  assign if0.O_bias = ob_v;
    assign if8.start_signal = start8;
    assign if8.inputs = in_v;  assign if8.H_weights = hw_v; assign if8.O_weights = ow_v;
    assign if8.H_bias = hb_v;  assign if8.O_bias = ob_v;

    neuron_layer_scheduler #(.INPUT_COUNT(IC), .H_NODE_NUMBER(HN), .O_NODE_NUMBER(ON),
                             .LANES(10), .FRAC(FRAC), .ACC_W(ACC_W))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    neuron_layer_scheduler #(.INPUT_COUNT(IC), .H_NODE_NUMBER(HN), .O_NODE_NUMBER(ON),
                             .LANES(8), .FRAC(FRAC), .ACC_W(ACC_W))
        u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_h [HN];
    int exp_o [ON];
    int exp_cls;
    logic [HN*8-1:0] exp_h_v;
    logic [ON*8-1:0] exp_o_v;

    function automatic int latency(input int lanes);
        return ((HN + lanes - 1) / lanes) * (IC + 2) + ((ON + lanes - 1) / lanes) * (HN + 2) + 1;
    endfunction

    function automatic int quantise(input int s_in);
        int s;
        s = (s_in << (32 - ACC_W)) >>> (32 - ACC_W);
        s = s >>> FRAC;
        if (s < 0) return 0;
        if (s > 127) return 127;
        return s;
    endfunction

    task automatic model();
        int s, best;
        for (int n = 0; n < HN; n++) begin
            s = int'(hb_a[n]) * (1 << FRAC);
            for (int i = 0; i < IC; i++) s += int'(x_a[i]) * int'(hw_a[n*IC+i]);
            exp_h[n] = quantise(s);
            exp_h_v[n*8 +: 8] = 8'(exp_h[n]);
        end
        for (int n = 0; n < ON; n++) begin
            s = int'(ob_a[n]) * (1 << FRAC);
            for (int j = 0; j < HN; j++) s += exp_h[j] * int'(ow_a[n*HN+j]);
            exp_o[n] = quantise(s);
            exp_o_v[n*8 +: 8] = 8'(exp_o[n]);
        end
        best = -1;
        exp_cls = 0;
        for (int n = 0; n < ON; n++)
            if (exp_o[n] > best) begin best = exp_o[n]; exp_cls = n; end
    endtask

    task automatic fill_random(input int xr, input int wr);
        for (int i = 0; i < IC; i++)    x_a[i]  = 8'(int'($urandom_range(2*xr)) - xr);
        for (int i = 0; i < HN*IC; i++) hw_a[i] = 8'(int'($urandom_range(2*wr)) - wr);
        for (int i = 0; i < ON*HN; i++) ow_a[i] = 8'(int'($urandom_range(2*wr)) - wr);
        for (int i = 0; i < HN; i++)    hb_a[i] = 8'($urandom);
        for (int i = 0; i < ON; i++)    ob_a[i] = 8'($urandom);
    endtask

    // Start a run and watch 400 cycles; rc is the cycle of the first ready (start edge = cycle 0).
    task automatic run(input bit use8, input int pa, input int pb,
                       output int rc, output int nr, output bit bok);
        logic r, b;
        @(negedge clk);
        if (use8) start8 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start8 = 1'b0;
        rc = -1; nr = 0; bok = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            r = use8 ? if8.ready_signal : if0.ready_signal;
            b = use8 ? if8.busy : if0.busy;
            if (r) begin
                nr++;
                if (rc < 0) rc = c;
                if (b) bok = 1'b0;
            end else if (rc < 0 && !b) begin
                bok = 1'b0;
            end
            if (c == pa || c == pb) begin
                if (use8) start8 = 1'b1; else start0 = 1'b1;
            end
            @(posedge clk); #1;
            start0 = 1'b0; start8 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (if0.busy !== 1'b0 || if0.ready_signal !== 1'b0)
            $display("FAIL reset_ctrl busy=%b ready=%b want 0 0", if0.busy, if0.ready_signal);
        else pass_cnt++;
        total_cnt++;
        if (if0.out_regs !== '0) $display("FAIL reset_out got %h want 0", if0.out_regs); else pass_cnt++;
        total_cnt++;
        if (if0.hidden_regs !== '0) $display("FAIL reset_hidden got %h want 0", if0.hidden_regs); else pass_cnt++;
        total_cnt++;
        if (if8.busy !== 1'b0 || if8.out_regs !== '0)
            $display("FAIL reset_dut8 busy=%b out=%h want 0", if8.busy, if8.out_regs);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_bias_only();
        int rc, nr; bit bok;
        for (int i = 0; i < IC; i++)    x_a[i]  = 8'($urandom);
        for (int i = 0; i < HN*IC; i++) hw_a[i] = 8'd0;
        for (int i = 0; i < ON*HN; i++) ow_a[i] = 8'd0;
        for (int i = 0; i < HN; i++)    hb_a[i] = 8'h20;
        for (int i = 0; i < ON; i++)    ob_a[i] = 8'(i*4);
        model();
        run(1'b0, 0, 0, rc, nr, bok);
        total_cnt++;
        if (rc !== latency(10)) $display("FAIL bias_latency got %0d want %0d", rc, latency(10)); else pass_cnt++;
        total_cnt++;
        if (if0.hidden_regs !== exp_h_v) $display("FAIL bias_hidden got %h want %h", if0.hidden_regs, exp_h_v); else pass_cnt++;
        total_cnt++;
        if (if0.out_regs !== exp_o_v) $display("FAIL bias_out got %h want %h", if0.out_regs, exp_o_v); else pass_cnt++;
        total_cnt++;
        if (if0.out_regs[7*8 +: 8] !== 8'd28) $display("FAIL bias_out7 got %0d want 28", if0.out_regs[7*8 +: 8]); else pass_cnt++;
    endtask

    task automatic test_saturation();
        int rc, nr; bit bok;
        for (int i = 0; i < IC; i++)    x_a[i]  = 8'h20;
        for (int i = 0; i < HN*IC; i++) hw_a[i] = 8'h20;
        for (int i = 0; i < ON*HN; i++) ow_a[i] = 8'd0;
        for (int i = 0; i < HN; i++)    hb_a[i] = 8'd0;
        for (int i = 0; i < ON; i++)    ob_a[i] = 8'hE0;
        model();
        run(1'b0, 0, 0, rc, nr, bok);
        total_cnt++;
        if (if0.hidden_regs !== {HN{8'h7F}}) $display("FAIL sat_hidden got %h want all 7f", if0.hidden_regs); else pass_cnt++;
        total_cnt++;
        if (if0.out_regs !== exp_o_v) $display("FAIL sat_out got %h want %h", if0.out_regs, exp_o_v); else pass_cnt++;
    endtask

    task automatic test_random();
        int rc, nr; bit bok;
        for (int t = 0; t < 3; t++) begin
            if (t == 2) fill_random(127, 127); else fill_random(64, 8);
            model();
            run(1'b0, 0, 0, rc, nr, bok);
            total_cnt++;
            if (rc !== latency(10) || nr !== 1) $display("FAIL rand%0d_ready cycle %0d count %0d want %0d 1", t, rc, nr, latency(10)); else pass_cnt++;
            total_cnt++;
            if (if0.hidden_regs !== exp_h_v) $display("FAIL rand%0d_hidden got %h want %h", t, if0.hidden_regs, exp_h_v); else pass_cnt++;
            total_cnt++;
            if (if0.out_regs !== exp_o_v) $display("FAIL rand%0d_out got %h want %h", t, if0.out_regs, exp_o_v); else pass_cnt++;
`ifdef ARGMAX_EN
            total_cnt++;
            if (if0.class_idx !== CW'(exp_cls)) $display("FAIL rand%0d_class got %0d want %0d", t, if0.class_idx, exp_cls); else pass_cnt++;
`endif
        end
    endtask

    task automatic test_partial_groups();
        int rc, nr; bit bok;
        for (int i = 0; i < IC; i++) x_a[i] = 8'(i + 1);
        for (int n = 0; n < HN; n++)
            for (int i = 0; i < IC; i++) hw_a[n*IC+i] = (i == n) ? 8'h20 : 8'h00;
        for (int n = 0; n < ON; n++)
            for (int j = 0; j < HN; j++) ow_a[n*HN+j] = (j == n) ? 8'h20 : 8'h00;
        for (int i = 0; i < HN; i++) hb_a[i] = 8'd0;
        for (int i = 0; i < ON; i++) ob_a[i] = 8'(i);
        model();
        run(1'b1, 0, 0, rc, nr, bok);
        total_cnt++;
        if (rc !== latency(8)) $display("FAIL part_latency got %0d want %0d", rc, latency(8)); else pass_cnt++;
        total_cnt++;
        if (if8.hidden_regs !== exp_h_v) $display("FAIL part_hidden got %h want %h", if8.hidden_regs, exp_h_v); else pass_cnt++;
        total_cnt++;
        if (if8.out_regs !== exp_o_v) $display("FAIL part_out got %h want %h", if8.out_regs, exp_o_v); else pass_cnt++;
        fill_random(64, 8);
        model();
        run(1'b1, 0, 0, rc, nr, bok);
        total_cnt++;
        if (if8.hidden_regs !== exp_h_v || if8.out_regs !== exp_o_v)
            $display("FAIL part_rand got %h/%h want %h/%h", if8.hidden_regs, if8.out_regs, exp_h_v, exp_o_v);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int rc, nr; bit bok;
        fill_random(64, 8);
        model();
        run(1'b0, 10, 150, rc, nr, bok);
        total_cnt++;
        if (nr !== 1 || rc !== latency(10)) $display("FAIL ignore_ready count %0d cycle %0d want 1 %0d", nr, rc, latency(10)); else pass_cnt++;
        total_cnt++;
        if (bok !== 1'b1) $display("FAIL ignore_busy got %b want 1", bok); else pass_cnt++;
        total_cnt++;
        if (if0.out_regs !== exp_o_v) $display("FAIL ignore_out got %h want %h", if0.out_regs, exp_o_v); else pass_cnt++;
        repeat (30) @(posedge clk);
        #1;
        total_cnt++;
        if (if0.out_regs !== exp_o_v || if0.busy !== 1'b0)
            $display("FAIL idle_stable out %h busy %b want %h 0", if0.out_regs, if0.busy, exp_o_v);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int rc, nr, late; bit bok;
        for (int i = 0; i < HN*IC; i++) hw_a[i] = 8'd0;
        for (int i = 0; i < ON*HN; i++) ow_a[i] = 8'd0;
        for (int i = 0; i < HN; i++)    hb_a[i] = 8'h20;
        for (int i = 0; i < ON; i++)    ob_a[i] = 8'(i*4 + 1);
        run(1'b0, 0, 0, rc, nr, bok);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int c = 1; c < 70; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (if0.busy !== 1'b0 || if0.ready_signal !== 1'b0)
            $display("FAIL abort_ctrl busy=%b ready=%b want 0 0", if0.busy, if0.ready_signal);
        else pass_cnt++;
        total_cnt++;
        if (if0.out_regs !== '0 || if0.hidden_regs !== '0)
            $display("FAIL abort_regs out %h hidden %h want 0", if0.out_regs, if0.hidden_regs);
        else pass_cnt++;
        late = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (if0.ready_signal) late++;
        end
        total_cnt++;
        if (late !== 0) $display("FAIL abort_no_ready got %0d pulses want 0", late); else pass_cnt++;
        fill_random(64, 8);
        model();
        run(1'b0, 0, 0, rc, nr, bok);
        total_cnt++;
        if (rc !== latency(10) || if0.out_regs !== exp_o_v)
            $display("FAIL abort_rerun cycle %0d out %h want %0d %h", rc, if0.out_regs, latency(10), exp_o_v);
        else pass_cnt++;
    endtask

`ifdef ARGMAX_EN
    task automatic test_argmax();
        int rc, nr; bit bok;
        logic [7:0] pat [4];
        pat[0] = 8'd5; pat[1] = 8'd9; pat[2] = 8'd9; pat[3] = 8'd2;
        for (int i = 0; i < HN*IC; i++) hw_a[i] = 8'd0;
        for (int i = 0; i < ON*HN; i++) ow_a[i] = 8'd0;
        for (int i = 0; i < HN; i++)    hb_a[i] = 8'd0;
        for (int i = 0; i < ON; i++)    ob_a[i] = (i < 4) ? pat[i] : 8'd0;
        model();
        run(1'b0, 0, 0, rc, nr, bok);
        total_cnt++;
        if (if0.class_idx !== CW'(1)) $display("FAIL argmax_tie got %0d want 1", if0.class_idx); else pass_cnt++;
        run(1'b1, 0, 0, rc, nr, bok);
        total_cnt++;
        if (if8.class_idx !== CW'(exp_cls)) $display("FAIL argmax_dut8 got %0d want %0d", if8.class_idx, exp_cls); else pass_cnt++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start8 = 1'b0;
        for (int i = 0; i < IC; i++)    x_a[i]  = 8'd0;
        for (int i = 0; i < HN*IC; i++) hw_a[i] = 8'd0;
        for (int i = 0; i < ON*HN; i++) ow_a[i] = 8'd0;
        for (int i = 0; i < HN; i++)    hb_a[i] = 8'd0;
        for (int i = 0; i < ON; i++)    ob_a[i] = 8'd0;
        test_reset();
        test_bias_only();
        test_saturation();
        test_random();
        test_partial_groups();
        test_start_ignored();
        test_reset_abort();
`ifdef ARGMAX_EN
        test_argmax();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
